// File: rtl/cpu16_pkg.sv
// Shared CPU16 definitions: ALU opcode map, flag register layout and opcode legality.
package cpu16_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_ADC   = 5'd2,  OP_SBC   = 5'd3,
    OP_ADDZ  = 5'd4,  OP_ADDNZ = 5'd5,  OP_ADDC  = 5'd6,  OP_ADDNC = 5'd7,
    OP_SUBZ  = 5'd8,  OP_SUBNZ = 5'd9,  OP_SUBC  = 5'd10, OP_SUBNC = 5'd11,
    OP_ADCZ  = 5'd12, OP_ADCNZ = 5'd13, OP_ADCC  = 5'd14, OP_ADCNC = 5'd15,
    OP_SBCZ  = 5'd16, OP_SBCNZ = 5'd17, OP_SBCC  = 5'd18, OP_SBCNC = 5'd19,
    OP_INC   = 5'd20, OP_DEC   = 5'd21, OP_AND   = 5'd22, OP_NAND  = 5'd23,
    OP_OR    = 5'd24, OP_XOR   = 5'd25, OP_SHL   = 5'd26, OP_SHR   = 5'd27
  } alu_op_e;

  localparam int ALU_OP_MAX = 27;

  typedef struct packed {
    logic z;
    logic c;
  } flags_t;

  function automatic logic opIsLegal(input logic [4:0] op);
    return op <= 5'(ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the port not granted last wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between execute (port 0) and AGU (port 1),
// owns the Z/C flag register and holds each result in a one-entry response buffer.
module alu_scheduler
  import cpu16_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][4:0] req_op,
  input  logic [1:0][15:0] req_a,
  input  logic [1:0][15:0] req_b,
  input  logic [1:0]      req_upd_flags,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_port,
  output logic [15:0]     resp_result,
  output logic            resp_cond_met,
  output logic            resp_illegal,
  input  logic            flags_load,
  input  logic [1:0]      flags_in,
  output logic            flag_z,
  output logic            flag_c,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [4:0]      alu_op,
  output logic            alu_enable,
  output logic            alu_zero_in,
  output logic            alu_carry_in,
  input  logic [16:0]     alu_out,
  input  logic            alu_zero_out,
  input  logic            alu_carry_out,
  input  logic            alu_cond_met
);

  if (N_REQ != 2) begin : gReqCheck
    $error("alu_scheduler supports exactly two requesters");
  end

  typedef enum logic {EMPTY, FULL} bufState_e;

  bufState_e  state;
  flags_t     flags;
  logic       canAccept;
  logic [1:0] reqGated;
  logic [1:0] gnt;
  logic       grant;
  logic       winPort;
  logic [4:0] winOp;
  logic       winUpd;
  logic       winLegal;
  logic       unusedAluMsb;

  // Refill is allowed in the same cycle the consumer drains a full buffer.
  assign canAccept = !rst && ((state == EMPTY) || resp_ready);
  assign reqGated  = req_valid & {2{canAccept}};

  rr_arbiter2 uArb (
    .clk     (clk),
    .rst     (rst),
    .req     (reqGated),
    .advance (grant),
    .gnt     (gnt)
  );

  assign grant    = |gnt;
  assign winPort  = gnt[1];
  assign winOp    = req_op[winPort];
  assign winUpd   = req_upd_flags[winPort];
  assign winLegal = opIsLegal(winOp);

  assign req_ready    = gnt;
  assign alu_enable   = grant;
  assign alu_a        = grant ? req_a[winPort] : 16'h0000;
  assign alu_b        = grant ? req_b[winPort] : 16'h0000;
  assign alu_op       = grant ? winOp : 5'd0;
  assign alu_zero_in  = flags.z;
  assign alu_carry_in = flags.c;
  assign flag_z       = flags.z;
  assign flag_c       = flags.c;
  assign resp_valid   = (state == FULL);
  assign unusedAluMsb = alu_out[16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      resp_port     <= 1'b0;
      resp_result   <= 16'h0000;
      resp_cond_met <= 1'b0;
      resp_illegal  <= 1'b0;
    end else if (grant) begin
      state         <= FULL;
      resp_port     <= winPort;
      resp_result   <= winLegal ? alu_out[15:0] : 16'h0000;
      resp_cond_met <= winLegal & alu_cond_met;
      resp_illegal  <= !winLegal;
    end else if (resp_ready) begin
      state <= EMPTY;
    end
  end

  // An explicit load overrides any ALU flag write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (flags_load) begin
      flags <= flags_t'(flags_in);
    end else if (grant && winUpd && alu_cond_met && winLegal) begin
      flags <= flags_t'({alu_zero_out, alu_carry_out});
    end
  end

endmodule
